// File: rtl/spi_slave_tx.sv
// rtl/spi_slave_tx.sv - SPI mode 0 slave transmit stage with hold register
//
// Shifts bytes out on miso under an external master's sck/cs_n, both of
// which are oversampled in the clk domain (clk >= 8x sck). A one-byte hold
// register buffers the upstream txd_en/txd_data strobe; when nothing is
// pending at a byte boundary IDLE_BYTE is sent instead.
//
// Optional feature macro: SPI_TX_OVERRUN_EN (adds sticky tx_overrun output).
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   sck        SPI clock from master (asynchronous)
//   cs_n       SPI chip select, active low (asynchronous)
//   txd_en     one-clk strobe, txd_data valid
//   txd_data   byte to transmit
//   miso       serial data to master
//   miso_oe    miso pad output enable, high while selected
//   tx_done    one-clk pulse after the 8th sck rising edge of a byte
//   hold_full  hold register contains a byte not yet loaded
//   tx_overrun (SPI_TX_OVERRUN_EN only) sticky: pending byte was overwritten

module spi_slave_tx #(
  parameter logic [7:0] IDLE_BYTE = 8'hFF,
  parameter bit         MSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck,
  input  logic       cs_n,
  input  logic       txd_en,
  input  logic [7:0] txd_data,
  output logic       miso,
  output logic       miso_oe,
  output logic       tx_done,
  output logic       hold_full
`ifdef SPI_TX_OVERRUN_EN
  ,
  output logic       tx_overrun
`endif
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0] state;
  logic [7:0] shreg;
  logic [7:0] hold;
  logic [2:0] bit_cnt;
  logic       boundary;

  // Two-flop synchronizers plus one history flop for edge detection.
  logic sck_s1, sck_s2, sck_h;
  logic cs_s1, cs_s2, cs_h;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_s1 <= 1'b0;
      sck_s2 <= 1'b0;
      sck_h  <= 1'b0;
      cs_s1  <= 1'b1;
      cs_s2  <= 1'b1;
      cs_h   <= 1'b1;
    end else begin
      sck_s1 <= sck;
      sck_s2 <= sck_s1;
      sck_h  <= sck_s2;
      cs_s1  <= cs_n;
      cs_s2  <= cs_s1;
      cs_h   <= cs_s2;
    end
  end

  logic sck_rise, sck_fall, cs_fall, cs_rise;
  assign sck_rise = sck_s2 & ~sck_h;
  assign sck_fall = ~sck_s2 & sck_h;
  assign cs_fall  = ~cs_s2 & cs_h;
  assign cs_rise  = cs_s2 & ~cs_h;

  // A load happens at frame start, or on the sck falling edge that follows
  // a completed byte. A cs_n rise outranks any sck edge in the same clk.
  logic       load_evt;
  logic [7:0] load_byte;
  logic [7:0] shift_next;

  assign load_evt = ((state == ST_IDLE) && cs_fall) ||
                    ((state == ST_SHIFT) && !cs_rise && !sck_rise && sck_fall && boundary);
  assign load_byte  = hold_full ? hold : IDLE_BYTE;
  assign shift_next = MSB_FIRST ? {shreg[6:0], 1'b0} : {1'b0, shreg[7:1]};

  assign miso_oe = (state == ST_SHIFT);
  assign miso    = (state == ST_SHIFT) ? (MSB_FIRST ? shreg[7] : shreg[0]) : 1'b0;

  // A strobe coinciding with a load lands in hold after the load has
  // taken the old contents, so hold_full stays set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold      <= 8'h00;
      hold_full <= 1'b0;
    end else if (txd_en) begin
      hold      <= txd_data;
      hold_full <= 1'b1;
    end else if (load_evt) begin
      hold_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      shreg    <= 8'h00;
      bit_cnt  <= 3'd0;
      boundary <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          bit_cnt  <= 3'd0;
          boundary <= 1'b0;
          if (cs_fall) begin
            shreg <= load_byte;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cs_rise) begin
            state    <= ST_IDLE;
            bit_cnt  <= 3'd0;
            boundary <= 1'b0;
          end else if (sck_rise) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              tx_done  <= 1'b1;
              boundary <= 1'b1;
            end
          end else if (sck_fall) begin
            if (boundary) begin
              shreg    <= load_byte;
              boundary <= 1'b0;
            end else begin
              shreg <= shift_next;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SPI_TX_OVERRUN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_overrun <= 1'b0;
    end else if (cs_fall) begin
      tx_overrun <= 1'b0;
    end else if (txd_en && hold_full && !load_evt) begin
      tx_overrun <= 1'b1;
    end
  end
`endif

endmodule
